multicycle_datapath: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle 16-bit MIPS datapath.

---
 rtl/multicycle_datapath_pkg.sv | 59 +++++
 rtl/multicycle_datapath_if.sv | 33 +++
 rtl/multicycle_datapath_alu.sv | 26 ++
 rtl/multicycle_datapath.sv | 159 +++++++++++++++
 tb/tb_multicycle_datapath.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_datapath_pkg.sv
// Shared types for the multi-cycle 16-bit MIPS-style datapath: instruction
// fields, opcodes, FSM states and ALU operation selection.
package multicycle_datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_SLT  = 4'h4,
        OP_ADDI = 4'h5,
        OP_LW   = 4'h6,
        OP_SW   = 4'h7,
        OP_BNE  = 4'h8,
        OP_BEQ  = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;

    // rd doubles as the 4-bit immediate for ADDI/LW/SW/branches.
    typedef struct packed {
        opcode_t    op;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
    } instr_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // Address arithmetic for ADDI/LW/SW rides on ADD; codes A..E never use the result.
    function automatic alu_op_t alu_op_for(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_rtype(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
    endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Instruction and data memory req/ack handshake bundle. The datapath is the
// master; memories of any latency sit on the slave side.
interface multicycle_datapath_if #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 6,
    parameter int DADDR_W = 4
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [15:0]        imem_rdata;

    logic               dmem_req;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ack;
    logic [DATA_W-1:0]  dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multicycle_datapath_alu.sv
// Combinational ALU: wrap-around ADD/SUB, bitwise AND/OR and signed SLT.
module multicycle_datapath_alu
    import multicycle_datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        // NOTE: defaulting y before the case keeps every path assigned, so no latch is inferred.
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit MIPS-style datapath: FETCH/DECODE/EXEC/MEM/WB FSM with
// req/ack memory handshakes, hardwired R0 and a DATA_W-wide register file.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 6,
    parameter int DADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_datapath_if.master bus,
    output logic [PC_W-1:0]       pc,
    output logic                  halted
);

    state_t             state;
    instr_t             ir;
    logic [DATA_W-1:0]  regs [1:15];
    logic [DATA_W-1:0]  a_q, b_q, alu_out, mdr;

    logic               imem_req_q;
    logic               dmem_req_q;
    logic               dmem_we_q;
    logic [DADDR_W-1:0] dmem_addr_q;
    logic [DATA_W-1:0]  dmem_wdata_q;

    logic [DATA_W-1:0]  rs_val, rt_val;
    logic [DATA_W-1:0]  imm_ext, alu_b, alu_y, wb_data;
    logic [PC_W-1:0]    imm_pc;
    logic [3:0]         wb_dest;
    logic               is_imm, branch_taken;
    alu_op_t            alu_op;

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;

    // R0 has no storage: it reads as zero and writes to it are dropped in WB.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (ir.rs != 4'd0) rs_val = regs[ir.rs];
        if (ir.rt != 4'd0) rt_val = regs[ir.rt];
    end

    assign imm_ext      = {{(DATA_W-4){ir.rd[3]}}, ir.rd};
    assign imm_pc       = {{(PC_W-4){ir.rd[3]}}, ir.rd};
    assign is_imm       = ir.op inside {OP_ADDI, OP_LW, OP_SW};
    assign alu_b        = is_imm ? imm_ext : b_q;
    assign alu_op       = alu_op_for(ir.op);
    assign branch_taken = (ir.op == OP_BEQ) == (a_q == b_q);
    assign wb_dest      = is_rtype(ir.op) ? ir.rd : ir.rt;
    assign wb_data      = (ir.op == OP_LW) ? mdr : alu_out;

    multicycle_datapath_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu_op),
        .a  (a_q),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= '0;
            ir           <= '0;
            a_q          <= '0;
            b_q          <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted       <= 1'b0;
            // NOTE: the register file is architecturally cleared on reset, so it is a flop array, not a RAM.
            for (int i = 1; i < 16; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // Request is raised on entry to FETCH; only the first cycle after reset raises it here.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (bus.imem_ack) begin
                        ir         <= instr_t'(bus.imem_rdata);
                        pc         <= pc + PC_W'(1);
                        imem_req_q <= 1'b0;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= rt_val;
                    if (ir.op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_y;
                    case (ir.op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: begin
                            state <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= (ir.op == OP_SW);
                            dmem_addr_q  <= alu_y[DADDR_W-1:0];
                            dmem_wdata_q <= b_q;
                            state        <= S_MEM;
                        end
                        OP_BNE, OP_BEQ: begin
                            // pc already holds the fall-through address.
                            if (branch_taken) pc <= pc + imm_pc;
                            imem_req_q <= 1'b1;
                            state      <= S_FETCH;
                        end
                        default: begin
                            imem_req_q <= 1'b1;
                            state      <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (ir.op == OP_LW) begin
                            mdr   <= bus.dmem_rdata;
                            state <= S_WB;
                        end else begin
                            imem_req_q <= 1'b1;
                            state      <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_dest != 4'd0) regs[wb_dest] <= wb_data;
                    imem_req_q <= 1'b1;
                    state      <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed program bench for multicycle_datapath: latency-programmable memory
// models, fetch/data transaction logs and hand-computed expected results.
module tb_multicycle_datapath;
    import multicycle_datapath_pkg::*;

    localparam int DATA_W  = 16;
    localparam int PC_W    = 6;
    localparam int DADDR_W = 4;

    typedef struct {
        logic we;
        int   addr;
        int   wdata;
        int   len;
    } dtxn_t;

    logic            clk;
    logic            rst_n;
    logic [PC_W-1:0] pc;
    logic            halted;

    multicycle_datapath_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W)) bus ();

    multicycle_datapath #(.DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    logic [15:0]       imem [0:63];
    logic [DATA_W-1:0] dmem [0:15];
    int imem_wait, dmem_wait;
    logic inject_imem, inject_dmem;

    int    cyc;
    int    fetch_addr[$];
    int    fetch_cyc[$];
    dtxn_t dlog[$];
    int    d_unstable;
    int    exp_addr[$];
    int    exp_delta[$];

    int n_vec = 0;
    int n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responders plus transaction monitors, all evaluated at the falling edge.
    initial begin : bus_model
        int   i_cnt, d_cnt, d_len;
        logic i_real, d_real, d_active, d_we;
        logic [DADDR_W-1:0] d_addr;
        logic [DATA_W-1:0]  d_wdata;
        dtxn_t t;
        i_cnt = 0; d_cnt = 0; d_len = 0; d_active = 1'b0;
        d_we = 1'b0; d_addr = '0; d_wdata = '0;
        cyc = 0; d_unstable = 0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 16'hF000;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            cyc++;
            i_real = 1'b0;
            if (bus.imem_req) begin
                if (i_cnt == imem_wait) begin
                    i_real = 1'b1;
                    i_cnt  = 0;
                end else begin
                    i_cnt++;
                end
            end else begin
                i_cnt = 0;
            end
            bus.imem_ack   = i_real | inject_imem;
            bus.imem_rdata = i_real ? imem[bus.imem_addr] : 16'hF000;
            if (bus.imem_req && bus.imem_ack) begin
                fetch_addr.push_back(int'(bus.imem_addr));
                fetch_cyc.push_back(cyc);
            end

            d_real = 1'b0;
            if (bus.dmem_req) begin
                if (!d_active) begin
                    d_active = 1'b1; d_len = 0; d_cnt = 0;
                    d_we = bus.dmem_we; d_addr = bus.dmem_addr; d_wdata = bus.dmem_wdata;
                end else if (d_we !== bus.dmem_we || d_addr !== bus.dmem_addr || d_wdata !== bus.dmem_wdata) begin
                    d_unstable++;
                end
                d_len++;
                if (d_cnt == dmem_wait) d_real = 1'b1;
                else d_cnt++;
            end else begin
                d_active = 1'b0;
            end
            bus.dmem_ack   = d_real | inject_dmem;
            bus.dmem_rdata = 16'hDEAD;
            if (d_real) begin
                if (d_we) dmem[d_addr] = d_wdata;
                else bus.dmem_rdata = dmem[d_addr];
                t.we = d_we; t.addr = int'(d_addr); t.wdata = int'(d_wdata); t.len = d_len;
                dlog.push_back(t);
                d_active = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        fetch_addr.delete();
        fetch_cyc.delete();
        dlog.delete();
        d_unstable = 0;
    endtask

    task automatic fill_nops();
        for (int i = 0; i < 64; i++) imem[i] = 16'hA000;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check(tag, halted, 1'b1);
    endtask

    task automatic check_fetches(input string tag);
        check({tag, "_fetch_count"}, fetch_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < fetch_addr.size(); i++)
            check($sformatf("%s_fetch_addr%0d", tag, i), fetch_addr[i], exp_addr[i]);
        for (int i = 0; i < exp_delta.size() && i + 1 < fetch_cyc.size(); i++)
            check($sformatf("%s_latency%0d", tag, i), fetch_cyc[i+1] - fetch_cyc[i], exp_delta[i]);
    endtask

    initial begin : main
        int a_regs[12] = '{0, 5, 7, 12, 12, 2, 1, 0, 'hFFFF, 1, 4, 13};
        int reqs;
        int n;

        rst_n = 1'b0;
        inject_imem = 1'b0;
        inject_dmem = 1'b0;
        imem_wait = 0;
        dmem_wait = 3;
        clear_logs();

        // Scenario A: ALU ops, ADDI, SW/LW with 3-cycle data wait, NOP, R0 write, HALT.
        fill_nops();
        imem[0]  = 16'h5015; imem[1]  = 16'h5027; imem[2]  = 16'h0123; imem[3]  = 16'h7032;
        imem[4]  = 16'h6042; imem[5]  = 16'h1215; imem[6]  = 16'h4126; imem[7]  = 16'h4217;
        imem[8]  = 16'h508F; imem[9]  = 16'h4819; imem[10] = 16'h213A; imem[11] = 16'h313B;
        imem[12] = 16'hA000; imem[13] = 16'h5003; imem[14] = 16'h7005; imem[15] = 16'hF000;
        dmem[5] = 16'hAAAA;
        repeat (2) step();
        check("rst_pc", pc, '0);
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_dmem_req", bus.dmem_req, 1'b0);
        check("rst_dmem_we", bus.dmem_we, 1'b0);
        check("rst_halted", halted, 1'b0);
        rst_n = 1'b1;
        step();
        check("boot_imem_req", bus.imem_req, 1'b1);
        check("boot_imem_addr", bus.imem_addr, '0);
        check("boot_halted", halted, 1'b0);

        wait_halt("a_halted", 400);
        exp_addr  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        exp_delta = '{4, 4, 4, 7, 8, 4, 4, 4, 4, 4, 4, 4, 3, 4, 7};
        check_fetches("a");
        for (int i = 1; i < 12; i++)
            check($sformatf("a_reg%0d", i), dut.regs[i], a_regs[i]);
        check("a_dtxn_count", dlog.size(), 3);
        if (dlog.size() == 3) begin
            check("a_sw_we", dlog[0].we, 1'b1);
            check("a_sw_addr", dlog[0].addr, 2);
            check("a_sw_wdata", dlog[0].wdata, 12);
            check("a_sw_req_cycles", dlog[0].len, 4);
            check("a_lw_we", dlog[1].we, 1'b0);
            check("a_lw_addr", dlog[1].addr, 2);
            check("a_lw_req_cycles", dlog[1].len, 4);
            check("a_sw_r0_addr", dlog[2].addr, 5);
            check("a_sw_r0_wdata", dlog[2].wdata, 0);
        end
        check("a_handshake_stable", d_unstable, 0);
        check("a_mem2", dmem[2], 12);
        check("a_mem5", dmem[5], 0);
        check("a_pc", pc, 16);
        reqs = 0;
        repeat (10) begin
            step();
            if (bus.imem_req || bus.dmem_req) reqs++;
        end
        check("a_halt_idle_reqs", reqs, 0);
        check("a_halt_no_fetch", fetch_addr.size(), 16);
        rst_n = 1'b0;
        #1;
        check("a_pulse_pc", pc, '0);
        check("a_pulse_halted", halted, 1'b0);

        // Scenario B: BEQ not taken, BEQ taken, BNE backwards from pc=5.
        clear_logs();
        fill_nops();
        imem[0] = 16'h5015; imem[1] = 16'h5027; imem[2] = 16'h9127;
        imem[3] = 16'h9001; imem[4] = 16'hF000; imem[5] = 16'h812E;
        repeat (2) step();
        rst_n = 1'b1;
        wait_halt("b_halted", 200);
        exp_addr  = '{0, 1, 2, 3, 5, 4};
        exp_delta = '{4, 4, 3, 3, 3};
        check_fetches("b");
        check("b_pc", pc, 5);

        // Scenario C: branch target below 0 wraps to 63; branch at 63 wraps to 1.
        rst_n = 1'b0;
        clear_logs();
        fill_nops();
        imem[0] = 16'h900E; imem[63] = 16'h9111; imem[1] = 16'hA000; imem[2] = 16'hF000;
        repeat (2) step();
        rst_n = 1'b1;
        wait_halt("c_halted", 200);
        exp_addr  = '{0, 63, 1, 2};
        exp_delta = '{3, 3, 3};
        check_fetches("c");
        check("c_pc", pc, 3);

        // Scenario D: reset lands mid-LW; ack without req must be ignored.
        rst_n = 1'b0;
        clear_logs();
        fill_nops();
        imem[0] = 16'h6013; imem[1] = 16'hF000;
        dmem[3] = 16'h1234;
        dmem_wait = 6;
        repeat (2) step();
        rst_n = 1'b1;
        n = 0;
        while (!bus.dmem_req && n < 100) begin
            step();
            n++;
        end
        check("d_lw_req_seen", bus.dmem_req, 1'b1);
        inject_imem = 1'b1;
        repeat (2) step();
        inject_imem = 1'b0;
        check("d_stray_imem_ack_halted", halted, 1'b0);
        check("d_stray_imem_ack_req", bus.dmem_req, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("d_rst_dmem_req", bus.dmem_req, 1'b0);
        check("d_rst_imem_req", bus.imem_req, 1'b0);
        check("d_rst_pc", pc, '0);
        clear_logs();
        inject_dmem = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        inject_dmem = 1'b0;
        wait_halt("d_halted", 200);
        exp_addr  = '{0, 1};
        exp_delta = '{11};
        check_fetches("d");
        check("d_reg1", dut.regs[1], 16'h1234);
        check("d_dtxn_count", dlog.size(), 1);
        if (dlog.size() == 1) begin
            check("d_lw_we", dlog[0].we, 1'b0);
            check("d_lw_addr", dlog[0].addr, 3);
            check("d_lw_req_cycles", dlog[0].len, 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
